// File: rtl/adder_test_ctrl.sv
// Exhaustive sequencer for an N-bit adder: applies every {cin,b,a} vector, waits LAT
// cycles, compares the DUT result with a+b+cin and records the mismatch count and first failure.
module adder_test_ctrl #(
  parameter int N    = 4,
  parameter int LAT  = 0,
  parameter int ERRW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N-1:0]    a,
  output logic [N-1:0]    b,
  output logic            cin,
  input  logic [N-1:0]    dut_sum,
  input  logic            dut_cout,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [ERRW-1:0] err_count,
  output logic [N-1:0]    fail_a,
  output logic [N-1:0]    fail_b,
  output logic            fail_cin,
  output logic [2:0]      dbg_state
);

  localparam int IW = 2 * N + 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] SETTLE_INIT = CW'((LAT > 0) ? LAT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic            cin_q, cin_d;
  logic [ERRW-1:0] err_q, err_d;
  logic [N-1:0]    fa_q, fa_d, fb_q, fb_d;
  logic            fc_q, fc_d;
  logic            flag_q, flag_d;
  logic [N:0]      exp_sum;
  logic            mismatch;

  assign exp_sum  = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
  assign mismatch = ({dut_cout, dut_sum} != exp_sum);

  // start and abort are plain levels sampled on each rising edge; there is no
  // handshake. start is only honoured in IDLE/DONE, abort in every state and wins.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    err_d   = err_q;
    fa_d    = fa_q;
    fb_d    = fb_q;
    fc_d    = fc_q;
    flag_d  = flag_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_d   = '0;
            err_d   = '0;
            fa_d    = '0;
            fb_d    = '0;
            fc_d    = 1'b0;
            flag_d  = 1'b0;
            state_d = S_APPLY;
          end
        end
        S_APPLY: begin
          {cin_d, b_d, a_d} = idx_q;
          if (LAT > 0) begin
            cnt_d   = SETTLE_INIT;
            state_d = S_SETTLE;
          end else begin
            state_d = S_CHECK;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) state_d = S_CHECK;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_q != '1) err_d = err_q + 1'b1;
            if (!flag_q) begin
              fa_d   = a_q;
              fb_d   = b_q;
              fc_d   = cin_q;
              flag_d = 1'b1;
            end
          end
          // Terminal vector leaves before the increment, so idx never wraps.
          if (&idx_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_APPLY;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      err_q   <= '0;
      fa_q    <= '0;
      fb_q    <= '0;
      fc_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      err_q   <= err_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fc_q    <= fc_d;
      flag_q  <= flag_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign cin       = cin_q;
  assign busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_cin  = fc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_test_ctrl.sv
// Bench for adder_test_ctrl: table of fault modes on an N=4/LAT=0 sequencer, plus
// pipelined-adder latency runs, saturation, abort and asynchronous reset sequences.
module tb_adder_test_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start_x = 1'b0;
  logic abort = 1'b0;
  int   mode = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // ---------------- u0: N=4, LAT=0, combinational adder with selectable fault
  logic [3:0]  u0_a, u0_b, u0_sum, u0_fa, u0_fb;
  logic        u0_cin, u0_cout, u0_busy, u0_done, u0_pass, u0_fc;
  logic [15:0] u0_err;
  logic [2:0]  u0_st;
  logic [4:0]  u0_full;

  always_comb begin
    u0_full = {1'b0, u0_a} + {1'b0, u0_b} + {4'd0, u0_cin};
    case (mode)
      1:       u0_full[0] = 1'b0;
      2:       u0_full[4] = 1'b1;
      3:       u0_full[3] = ~u0_full[3];
      default: ;
    endcase
    {u0_cout, u0_sum} = u0_full;
  end

  adder_test_ctrl #(.N(4), .LAT(0), .ERRW(16)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(u0_a), .b(u0_b), .cin(u0_cin), .dut_sum(u0_sum), .dut_cout(u0_cout),
    .busy(u0_busy), .done(u0_done), .pass(u0_pass), .err_count(u0_err),
    .fail_a(u0_fa), .fail_b(u0_fb), .fail_cin(u0_fc), .dbg_state(u0_st));

  // ---------------- u1: N=4, LAT=2, two-stage registered adder
  logic [3:0]  u1_a, u1_b, u1_fa, u1_fb;
  logic        u1_cin, u1_busy, u1_done, u1_pass, u1_fc;
  logic [15:0] u1_err;
  logic [2:0]  u1_st;
  logic [4:0]  u1_r1, u1_r2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u1_r1 <= '0;
      u1_r2 <= '0;
    end else begin
      u1_r1 <= {1'b0, u1_a} + {1'b0, u1_b} + {4'd0, u1_cin};
      u1_r2 <= u1_r1;
    end
  end

  adder_test_ctrl #(.N(4), .LAT(2), .ERRW(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .abort(abort),
    .a(u1_a), .b(u1_b), .cin(u1_cin), .dut_sum(u1_r2[3:0]), .dut_cout(u1_r2[4]),
    .busy(u1_busy), .done(u1_done), .pass(u1_pass), .err_count(u1_err),
    .fail_a(u1_fa), .fail_b(u1_fb), .fail_cin(u1_fc), .dbg_state(u1_st));

  // ---------------- u3: N=4, LAT=1 on the same two-stage adder (too short)
  logic [3:0]  u3_a, u3_b, u3_fa, u3_fb;
  logic        u3_cin, u3_busy, u3_done, u3_pass, u3_fc;
  logic [15:0] u3_err;
  logic [2:0]  u3_st;
  logic [4:0]  u3_r1, u3_r2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u3_r1 <= '0;
      u3_r2 <= '0;
    end else begin
      u3_r1 <= {1'b0, u3_a} + {1'b0, u3_b} + {4'd0, u3_cin};
      u3_r2 <= u3_r1;
    end
  end

  adder_test_ctrl #(.N(4), .LAT(1), .ERRW(16)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .abort(abort),
    .a(u3_a), .b(u3_b), .cin(u3_cin), .dut_sum(u3_r2[3:0]), .dut_cout(u3_r2[4]),
    .busy(u3_busy), .done(u3_done), .pass(u3_pass), .err_count(u3_err),
    .fail_a(u3_fa), .fail_b(u3_fb), .fail_cin(u3_fc), .dbg_state(u3_st));

  // ---------------- u2: N=2, ERRW=3, carry-out stuck at 1
  logic [1:0] u2_a, u2_b, u2_fa, u2_fb;
  logic       u2_cin, u2_busy, u2_done, u2_pass, u2_fc;
  logic [2:0] u2_err;
  logic [2:0] u2_st;
  logic [2:0] u2_full;

  assign u2_full = {1'b0, u2_a} + {1'b0, u2_b} + {2'd0, u2_cin};

  adder_test_ctrl #(.N(2), .LAT(0), .ERRW(3)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_x), .abort(abort),
    .a(u2_a), .b(u2_b), .cin(u2_cin), .dut_sum(u2_full[1:0]), .dut_cout(1'b1),
    .busy(u2_busy), .done(u2_done), .pass(u2_pass), .err_count(u2_err),
    .fail_a(u2_fa), .fail_b(u2_fb), .fail_cin(u2_fc), .dbg_state(u2_st));

  // ---------------- checking helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start u0 and count busy cycles; abort_at/extra_at inject a one-cycle
  // abort/start pulse on that loop iteration (0 = never).
  task automatic run_u0(input int abort_at, input int extra_at, output int cyc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (u0_busy && cyc < 5000) begin
      cyc++;
      abort = (cyc == abort_at);
      start = (cyc == extra_at);
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  typedef struct {
    int mode;
    int exp_err;
    int exp_fa;
    int exp_fb;
    int exp_fc;
    int exp_pass;
  } vec_t;

  vec_t tbl[4];
  int   cyc;

  initial begin
    tbl[0] = '{mode: 0, exp_err: 0,   exp_fa: 0, exp_fb: 0, exp_fc: 0, exp_pass: 1};
    tbl[1] = '{mode: 1, exp_err: 256, exp_fa: 1, exp_fb: 0, exp_fc: 0, exp_pass: 0};
    tbl[2] = '{mode: 2, exp_err: 256, exp_fa: 0, exp_fb: 0, exp_fc: 0, exp_pass: 0};
    tbl[3] = '{mode: 3, exp_err: 512, exp_fa: 0, exp_fb: 0, exp_fc: 0, exp_pass: 0};

    // reset
    repeat (3) @(negedge clk);
    chk("reset_state", u0_st, 0);
    chk("reset_busy_done_pass", {u0_busy, u0_done, u0_pass}, 0);
    chk("reset_abc", {u0_a, u0_b, u0_cin}, 0);
    chk("reset_err", u0_err, 0);
    chk("reset_fail", {u0_fa, u0_fb, u0_fc}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", u0_busy, 0);

    // table of fault modes; each row restarts from DONE
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_u0(0, 0, cyc);
      chk($sformatf("row%0d_cycles", i), cyc, 1024);
      chk($sformatf("row%0d_done", i), {u0_done, u0_busy}, 2'b10);
      chk($sformatf("row%0d_err", i), u0_err, tbl[i].exp_err);
      chk($sformatf("row%0d_fail_a", i), u0_fa, tbl[i].exp_fa);
      chk($sformatf("row%0d_fail_b", i), u0_fb, tbl[i].exp_fb);
      chk($sformatf("row%0d_fail_cin", i), u0_fc, tbl[i].exp_fc);
      chk($sformatf("row%0d_pass", i), u0_pass, tbl[i].exp_pass);
      chk($sformatf("row%0d_last_vec", i), {u0_cin, u0_b, u0_a}, 9'h1FF);
    end

    // latency and saturation instances
    @(negedge clk) start_x = 1'b1;
    @(negedge clk) start_x = 1'b0;
    cyc = 0;
    while (u1_busy && cyc < 3000) begin
      cyc++;
      @(negedge clk);
    end
    chk("lat2_cycles", cyc, 2048);
    chk("lat2_done_pass", {u1_done, u1_pass}, 2'b11);
    chk("lat2_err", u1_err, 0);
    chk("lat1_done", u3_done, 1);
    chk("lat1_pass", u3_pass, 0);
    chk("lat1_err_nonzero", (u3_err != 0), 1);
    chk("sat_err", u2_err, 7);
    chk("sat_done_pass", {u2_done, u2_pass}, 2'b10);
    chk("sat_fail", {u2_fa, u2_fb, u2_fc}, 0);

    // abort after vectors 0..49 have been checked, while vector 50 is in APPLY
    mode = 1;
    run_u0(101, 0, cyc);
    chk("abort_cycles", cyc, 101);
    chk("abort_state", u0_st, 0);
    chk("abort_busy_done_pass", {u0_busy, u0_done, u0_pass}, 0);
    chk("abort_err_kept", u0_err, 25);
    chk("abort_fail_kept", {u0_fa, u0_fb, u0_fc}, {4'd1, 4'd0, 1'b0});
    chk("abort_abc_hold", {u0_a, u0_b, u0_cin}, {4'd1, 4'd3, 1'b0});
    mode = 0;
    run_u0(0, 0, cyc);
    chk("rerun_cycles", cyc, 1024);
    chk("rerun_pass", {u0_done, u0_pass, u0_err}, {2'b11, 16'd0});

    // asynchronous reset mid-run
    mode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (37) @(negedge clk);
    chk("pre_reset_busy", u0_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_state", {u0_st, u0_busy, u0_done, u0_pass}, 0);
    chk("async_reset_err", u0_err, 0);
    chk("async_reset_fail_abc", {u0_fa, u0_fb, u0_fc, u0_a, u0_b, u0_cin}, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", {u0_busy, u0_done}, 0);

    // start pulses while busy are ignored
    mode = 0;
    run_u0(0, 500, cyc);
    chk("extra_start_cycles", cyc, 1024);
    chk("extra_start_pass", {u0_done, u0_pass}, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
